// File: rtl/motor_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------------------------
// motor_cmd_sequencer_if
//
// Word-level link between the SSP slave and the motor command sequencer.
//
// Signals:
//   word_received  SSP word-complete level; a rising edge marks a new received word.
//   recvd_data     16-bit word received from the host; stable while word_received is high.
//   word_to_send   16-bit reply word presented to the SSP slave for the next transfer.
//
// Modports:
//   master  SSP side: drives word_received / recvd_data, reads word_to_send.
//   slave   sequencer side: reads word_received / recvd_data, drives word_to_send.
// ---------------------------------------------------------------------------------------------
interface motor_cmd_sequencer_if;

  logic        word_received;
  logic [15:0] recvd_data;
  logic [15:0] word_to_send;

  modport master (
    output word_received,
    output recvd_data,
    input  word_to_send
  );

  modport slave (
    input  word_received,
    input  recvd_data,
    output word_to_send
  );

endinterface

// File: rtl/motor_cmd_sequencer.sv
// ---------------------------------------------------------------------------------------------
// motor_cmd_sequencer
//
// Decodes the two-word SPI command protocol (header word, then data word) arriving from the SSP
// slave and routes each command to one addressed motorCtrlSimple step generator. Holds every
// motor's divider, direction and enable registers, pulses per-motor position resets and latches
// the addressed motor's position for the SSP reply word. A global command watchdog clears all
// step enables when no command has been committed for WDOG_CYCLES clocks.
//
// Word formats:
//   header (bit15=0): [3:0] motor number, [4] direction, [5] position reset, [14:6] ignored
//   data   (bit15=1): [DIV_W-1:0] divider, [13] step enable
//
// Ports:
//   CLK             system clock
//   reset           synchronous, active-high reset
//   ssp             SSP word link (word_received, recvd_data in; word_to_send out)
//   cur_position    flattened positions, motor m at [m*POS_W +: POS_W]
//   divider         flattened dividers, motor m at [m*DIV_W +: DIV_W]
//   move_dir        direction per motor
//   step_clock_ena  step enable per motor
//   pos_reset       one-cycle position-reset pulse per motor
//   cmd_error       sticky protocol-error flag, cleared by the next valid header
//   wdog_trip       sticky watchdog-expired flag, cleared by the next commit
//
// All outputs are registered; every accepted word takes effect one CLK after acceptance.
// ---------------------------------------------------------------------------------------------
module motor_cmd_sequencer #(
  parameter int unsigned NUM_MOTORS  = 7,
  parameter int unsigned DIV_W       = 13,
  parameter int unsigned POS_W       = 20,
  parameter int unsigned WDOG_CYCLES = 1000000
) (
  input  logic                          CLK,
  input  logic                          reset,
  motor_cmd_sequencer_if.slave          ssp,
  input  logic [NUM_MOTORS*POS_W-1:0]   cur_position,
  output logic [NUM_MOTORS*DIV_W-1:0]   divider,
  output logic [NUM_MOTORS-1:0]         move_dir,
  output logic [NUM_MOTORS-1:0]         step_clock_ena,
  output logic [NUM_MOTORS-1:0]         pos_reset,
  output logic                          cmd_error,
  output logic                          wdog_trip
);

  // A zero-cycle watchdog is disabled; keep a one-bit counter so the logic stays well formed.
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam logic [WDOG_W-1:0] WdogLoad = WDOG_W'(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WdogOne  = WDOG_W'(1);
  localparam bit WdogEnabled = (WDOG_CYCLES > 0);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHdr  = 1'b1;

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic                        wr_q;
  logic [0:0]                  state_q, state_d;
  logic [3:0]                  hdr_m_q, hdr_m_d;
  logic                        hdr_dir_q, hdr_dir_d;
  logic [NUM_MOTORS*DIV_W-1:0] divider_q, divider_d;
  logic [NUM_MOTORS-1:0]       move_dir_q, move_dir_d;
  logic [NUM_MOTORS-1:0]       ena_q, ena_d;
  logic [NUM_MOTORS-1:0]       pos_reset_q, pos_reset_d;
  logic [15:0]                 reply_q, reply_d;
  logic                        cmd_error_q, cmd_error_d;
  logic                        wdog_trip_q, wdog_trip_d;
  logic [WDOG_W-1:0]           wdog_cnt_q, wdog_cnt_d;

  // ---------------------------------------------------------------------------------------------
  // Word decode
  // ---------------------------------------------------------------------------------------------
  logic             accept;
  logic             is_data;
  logic [3:0]       w_m;
  logic             w_dir;
  logic             w_prst;
  logic [DIV_W-1:0] w_div;
  logic             w_ena;
  logic             m_ok;
  logic             hdr_ok;
  logic             hdr_bad;
  logic             commit;
  logic             data_bad;
  logic             expire;
  logic [15:0]      reply_sel;

  // Only the first sampled-high cycle of word_received counts, so a held level is one word.
  assign accept  = ssp.word_received & ~wr_q;
  assign is_data = ssp.recvd_data[15];
  assign w_m     = ssp.recvd_data[3:0];
  assign w_dir   = ssp.recvd_data[4];
  assign w_prst  = ssp.recvd_data[5];
  assign w_div   = ssp.recvd_data[DIV_W-1:0];
  assign w_ena   = ssp.recvd_data[13];
  assign m_ok    = (32'(w_m) < NUM_MOTORS);

  assign hdr_ok   = accept & ~is_data & m_ok;
  assign hdr_bad  = accept & ~is_data & ~m_ok;
  assign commit   = accept & is_data & (state_q == StHdr);
  assign data_bad = accept & is_data & (state_q == StIdle);

  // Expiry is the edge where the counter steps from 1 to 0; a commit on that edge takes priority.
  assign expire = WdogEnabled && (wdog_cnt_q == WdogOne) && !commit;

  // Upper 16 position bits of the motor named in the incoming header.
  always_comb begin
    reply_sel = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (w_m == 4'(i)) begin
        reply_sel = cur_position[i*POS_W + POS_W - 1 -: 16];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    hdr_m_d     = hdr_m_q;
    hdr_dir_d   = hdr_dir_q;
    divider_d   = divider_q;
    move_dir_d  = move_dir_q;
    ena_d       = ena_q;
    pos_reset_d = '0;
    reply_d     = reply_q;
    cmd_error_d = cmd_error_q;
    wdog_trip_d = wdog_trip_q;
    wdog_cnt_d  = (wdog_cnt_q != '0) ? (wdog_cnt_q - WdogOne) : wdog_cnt_q;

    if (hdr_ok) begin
      // A header in StHdr simply replaces the pending one.
      state_d     = StHdr;
      hdr_m_d     = w_m;
      hdr_dir_d   = w_dir;
      reply_d     = reply_sel;
      cmd_error_d = 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (w_m == 4'(i)) begin
          pos_reset_d[i] = w_prst;
        end
      end
    end else if (hdr_bad) begin
      state_d     = StIdle;
      cmd_error_d = 1'b1;
    end else if (commit) begin
      state_d     = StIdle;
      wdog_cnt_d  = WdogLoad;
      wdog_trip_d = 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (hdr_m_q == 4'(i)) begin
          divider_d[i*DIV_W +: DIV_W] = w_div;
          move_dir_d[i]               = hdr_dir_q;
          ena_d[i]                    = w_ena;
        end
      end
    end else if (data_bad) begin
      cmd_error_d = 1'b1;
    end

    // Dividers and directions survive a trip so the host can simply re-enable.
    if (expire) begin
      ena_d       = '0;
      wdog_trip_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_q        <= 1'b0;
      state_q     <= StIdle;
      hdr_m_q     <= '0;
      hdr_dir_q   <= 1'b0;
      divider_q   <= '0;
      move_dir_q  <= '0;
      ena_q       <= '0;
      pos_reset_q <= '0;
      reply_q     <= '0;
      cmd_error_q <= 1'b0;
      wdog_trip_q <= 1'b0;
      wdog_cnt_q  <= WdogLoad;
    end else begin
      wr_q        <= ssp.word_received;
      state_q     <= state_d;
      hdr_m_q     <= hdr_m_d;
      hdr_dir_q   <= hdr_dir_d;
      divider_q   <= divider_d;
      move_dir_q  <= move_dir_d;
      ena_q       <= ena_d;
      pos_reset_q <= pos_reset_d;
      reply_q     <= reply_d;
      cmd_error_q <= cmd_error_d;
      wdog_trip_q <= wdog_trip_d;
      wdog_cnt_q  <= wdog_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign divider          = divider_q;
  assign move_dir         = move_dir_q;
  assign step_clock_ena   = ena_q;
  assign pos_reset        = pos_reset_q;
  assign ssp.word_to_send = reply_q;
  assign cmd_error        = cmd_error_q;
  assign wdog_trip        = wdog_trip_q;

  // Ignored header bits and the low position bits never reach the reply word.
  logic unused_inputs;
  assign unused_inputs = ^{ssp.recvd_data, cur_position};

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
module tb_motor_cmd_sequencer;

  localparam int NM    = 7;
  localparam int DW    = 13;
  localparam int PW    = 20;
  localparam int WDOG  = 100;

  logic                CLK;
  logic                reset;
  logic [NM*PW-1:0]    cur_position;
  logic [NM*DW-1:0]    divider;
  logic [NM-1:0]       move_dir;
  logic [NM-1:0]       step_clock_ena;
  logic [NM-1:0]       pos_reset;
  logic                cmd_error;
  logic                wdog_trip;

  motor_cmd_sequencer_if ssp_if ();

  motor_cmd_sequencer #(
    .NUM_MOTORS  (NM),
    .DIV_W       (DW),
    .POS_W       (PW),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .ssp            (ssp_if),
    .cur_position   (cur_position),
    .divider        (divider),
    .move_dir       (move_dir),
    .step_clock_ena (step_clock_ena),
    .pos_reset      (pos_reset),
    .cmd_error      (cmd_error),
    .wdog_trip      (wdog_trip)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0]          word;
    logic                 err;
    logic [NM-1:0]        prst;
    logic [NM-1:0]        ena;
    logic [NM-1:0]        dir;
    logic [15:0]          wts;
    logic [NM-1:0][DW-1:0] div;
  } vec_t;

  vec_t tv[13];
  int   nv;
  int   checks;
  int   errors;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected divider bank is the previous entry's with at most one motor (dm < NM) rewritten.
  task automatic add(input logic [15:0] w, input logic err, input logic [NM-1:0] prst,
                     input logic [NM-1:0] ena, input logic [NM-1:0] dir, input logic [15:0] wts,
                     input int dm, input logic [DW-1:0] dv);
    logic [NM-1:0][DW-1:0] base;
    base = (nv > 0) ? tv[nv-1].div : '0;
    if (dm < NM) base[dm] = dv;
    tv[nv].word = w;
    tv[nv].err  = err;
    tv[nv].prst = prst;
    tv[nv].ena  = ena;
    tv[nv].dir  = dir;
    tv[nv].wts  = wts;
    tv[nv].div  = base;
    nv++;
  endtask

  // Starts at a negedge; returns at the negedge just after the acceptance edge.
  task automatic send_word(input logic [15:0] w);
    @(negedge CLK);
    ssp_if.recvd_data    = w;
    ssp_if.word_received = 1'b1;
    @(negedge CLK);
    ssp_if.word_received = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset                = 1'b1;
    ssp_if.word_received = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic set_pos(input int m, input logic [PW-1:0] v);
    cur_position[m*PW +: PW] = v;
  endtask

  logic [NM-1:0][DW-1:0] ediv;
  int pulses;

  initial begin
    checks = 0;
    errors = 0;
    nv     = 0;
    reset  = 1'b1;
    ssp_if.word_received = 1'b0;
    ssp_if.recvd_data    = 16'h0000;
    cur_position = '0;
    set_pos(0, 20'h00010);
    set_pos(1, 20'hFEDCB);
    set_pos(2, 20'h12345);
    set_pos(3, 20'h6789A);
    set_pos(4, 20'h55AA5);
    set_pos(5, 20'hABCDE);
    set_pos(6, 20'h0F0F0);

    //   word      err  prst   ena    dir    wts      motor div
    add(16'h8005, 1'b1, 7'h00, 7'h00, 7'h00, 16'h0000, NM, '0);
    add(16'h0009, 1'b1, 7'h00, 7'h00, 7'h00, 16'h0000, NM, '0);
    add(16'h0023, 1'b0, 7'h08, 7'h00, 7'h00, 16'h6789, NM, '0);
    add(16'hA064, 1'b0, 7'h00, 7'h08, 7'h00, 16'h6789, 3,  13'h0064);
    add(16'h0012, 1'b0, 7'h00, 7'h08, 7'h00, 16'h1234, NM, '0);
    add(16'h8010, 1'b0, 7'h00, 7'h08, 7'h04, 16'h1234, 2,  13'h0010);
    add(16'h0001, 1'b0, 7'h00, 7'h08, 7'h04, 16'hFEDC, NM, '0);
    add(16'h0034, 1'b0, 7'h10, 7'h08, 7'h04, 16'h55AA, NM, '0);
    add(16'hA0FF, 1'b0, 7'h00, 7'h18, 7'h14, 16'h55AA, 4,  13'h00FF);
    add(16'h8005, 1'b1, 7'h00, 7'h18, 7'h14, 16'h55AA, NM, '0);
    add(16'h0000, 1'b0, 7'h00, 7'h18, 7'h14, 16'h0001, NM, '0);
    add(16'h0016, 1'b0, 7'h00, 7'h18, 7'h14, 16'h0F0F, NM, '0);
    add(16'h9FFF, 1'b0, 7'h00, 7'h18, 7'h54, 16'h0F0F, 6,  13'h1FFF);

    // Reset state
    do_reset();
    chk("rst divider", 128'(divider), 128'(0));
    chk("rst ena", 128'(step_clock_ena), 128'(0));
    chk("rst dir", 128'(move_dir), 128'(0));
    chk("rst prst", 128'(pos_reset), 128'(0));
    chk("rst wts", 128'(ssp_if.word_to_send), 128'(0));
    chk("rst err", 128'(cmd_error), 128'(0));
    chk("rst trip", 128'(wdog_trip), 128'(0));

    // Table-driven protocol vectors
    for (int i = 0; i < nv; i++) begin
      send_word(tv[i].word);
      chk($sformatf("v%0d err", i), 128'(cmd_error), 128'(tv[i].err));
      chk($sformatf("v%0d prst", i), 128'(pos_reset), 128'(tv[i].prst));
      chk($sformatf("v%0d ena", i), 128'(step_clock_ena), 128'(tv[i].ena));
      chk($sformatf("v%0d dir", i), 128'(move_dir), 128'(tv[i].dir));
      chk($sformatf("v%0d wts", i), 128'(ssp_if.word_to_send), 128'(tv[i].wts));
      chk($sformatf("v%0d div", i), 128'(divider), 128'(tv[i].div));
      chk($sformatf("v%0d trip", i), 128'(wdog_trip), 128'(0));
    end

    // Reply word holds while the position moves
    do_reset();
    send_word(16'h0012);
    chk("hold wts0", 128'(ssp_if.word_to_send), 128'(16'h1234));
    set_pos(2, 20'hABCDE);
    repeat (3) @(negedge CLK);
    chk("hold wts1", 128'(ssp_if.word_to_send), 128'(16'h1234));
    send_word(16'h8010);
    chk("hold dir", 128'(move_dir), 128'(7'h04));
    chk("hold ena", 128'(step_clock_ena), 128'(7'h00));
    set_pos(2, 20'h12345);

    // Held word_received: one pulse, one commit
    do_reset();
    @(negedge CLK);
    ssp_if.recvd_data    = 16'h0025;
    ssp_if.word_received = 1'b1;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (pos_reset[5]) pulses++;
      if (c == 1) chk("prst width", 128'(pos_reset), 128'(0));
    end
    ssp_if.word_received = 1'b0;
    chk("held hdr pulses", 128'(pulses), 128'(1));
    @(negedge CLK);
    ssp_if.recvd_data    = 16'hA003;
    ssp_if.word_received = 1'b1;
    repeat (50) @(negedge CLK);
    ssp_if.word_received = 1'b0;
    @(negedge CLK);
    ediv = '0;
    ediv[5] = 13'h0003;
    chk("held data err", 128'(cmd_error), 128'(0));
    chk("held data div", 128'(divider), 128'(ediv));
    chk("held data ena", 128'(step_clock_ena), 128'(7'h20));

    // Watchdog expiry exactly WDOG cycles after the last commit
    do_reset();
    send_word(16'h0000);
    send_word(16'hA00A);
    send_word(16'h0005);
    send_word(16'hA00B);
    repeat (WDOG - 1) @(negedge CLK);
    chk("wd pre ena", 128'(step_clock_ena), 128'(7'h21));
    chk("wd pre trip", 128'(wdog_trip), 128'(0));
    @(negedge CLK);
    ediv = '0;
    ediv[0] = 13'h000A;
    ediv[5] = 13'h000B;
    chk("wd ena", 128'(step_clock_ena), 128'(0));
    chk("wd trip", 128'(wdog_trip), 128'(1));
    chk("wd div kept", 128'(divider), 128'(ediv));

    // Commit landing on the expiry edge wins; counter reloads from it
    do_reset();
    send_word(16'h0000);
    send_word(16'hA00A);
    repeat (48) @(negedge CLK);
    send_word(16'h0006);
    repeat (48) @(negedge CLK);
    send_word(16'hA007);
    ediv = '0;
    ediv[0] = 13'h000A;
    ediv[6] = 13'h0007;
    chk("wd race trip", 128'(wdog_trip), 128'(0));
    chk("wd race ena", 128'(step_clock_ena), 128'(7'h41));
    chk("wd race div", 128'(divider), 128'(ediv));
    repeat (WDOG - 1) @(negedge CLK);
    chk("wd reload pre", 128'(wdog_trip), 128'(0));
    @(negedge CLK);
    chk("wd reload trip", 128'(wdog_trip), 128'(1));
    chk("wd reload ena", 128'(step_clock_ena), 128'(0));

    // Reset between header and data discards the header
    do_reset();
    send_word(16'h0003);
    send_word(16'hA001);
    send_word(16'h0022);
    chk("mid prst", 128'(pos_reset), 128'(7'h04));
    chk("mid wts", 128'(ssp_if.word_to_send), 128'(16'h1234));
    do_reset();
    chk("mid rst div", 128'(divider), 128'(0));
    chk("mid rst ena", 128'(step_clock_ena), 128'(0));
    chk("mid rst wts", 128'(ssp_if.word_to_send), 128'(0));
    chk("mid rst prst", 128'(pos_reset), 128'(0));
    send_word(16'hA005);
    chk("mid data err", 128'(cmd_error), 128'(1));
    chk("mid data div", 128'(divider), 128'(0));
    chk("mid data ena", 128'(step_clock_ena), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
